// File: rtl/shift_add_mult.sv
// 8x8 unsigned sequential shift-and-add multiplier: one partial product per BUSY
// cycle through a 16-bit carry-lookahead adder, result registered on DONE entry.
module shift_add_mult (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] product,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] mcand_q, mcand_d;
   logic [7:0]  mplier_q, mplier_d;
   logic [15:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] product_q, product_d;

   logic [15:0] add_g, add_p, carry, add_sum;
   logic [3:0]  grp_g, grp_p;
   logic [4:0]  grp_c;
   logic        add_cout;

   // Two-level lookahead: 4-bit groups, group carries resolved in parallel.
   always_comb begin
      add_g = acc_q & mcand_q;
      add_p = acc_q ^ mcand_q;
      for (int unsigned j = 0; j < 4; j++) begin
         grp_g[j] = add_g[4*j+3]
                  | (add_p[4*j+3] & add_g[4*j+2])
                  | (add_p[4*j+3] & add_p[4*j+2] & add_g[4*j+1])
                  | (add_p[4*j+3] & add_p[4*j+2] & add_p[4*j+1] & add_g[4*j]);
         grp_p[j] = &add_p[4*j +: 4];
      end
      grp_c[0] = 1'b0;
      grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & grp_c[0]);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
      grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
      for (int unsigned j = 0; j < 4; j++) begin
         carry[4*j]   = grp_c[j];
         carry[4*j+1] = add_g[4*j] | (add_p[4*j] & grp_c[j]);
         carry[4*j+2] = add_g[4*j+1] | (add_p[4*j+1] & add_g[4*j])
                      | (add_p[4*j+1] & add_p[4*j] & grp_c[j]);
         carry[4*j+3] = add_g[4*j+2] | (add_p[4*j+2] & add_g[4*j+1])
                      | (add_p[4*j+2] & add_p[4*j+1] & add_g[4*j])
                      | (add_p[4*j+2] & add_p[4*j+1] & add_p[4*j] & grp_c[j]);
      end
      add_sum  = add_p ^ carry;
      add_cout = grp_c[4];
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d  = {8'h00, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = BUSY;
            end else begin
               state_d  = IDLE;
            end
         end
         BUSY: begin
            if (mplier_q[0]) acc_d = add_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d   = DONE;
               product_d = mplier_q[0] ? add_sum : acc_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;
   assign busy    = (state_q == BUSY);
   assign done    = (state_q == DONE);

   // Partial sums never exceed 255*255, so an accepted add must not carry out.
   a_no_carry_out: assert property (@(posedge clk) disable iff (rst)
      (state_q == BUSY && mplier_q[0]) |-> !add_cout);

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized self-checking bench for shift_add_mult; the reference result is
// plain a*b and timing is checked against the 8-busy/1-done cycle contract.
module tb_shift_add_mult;

   logic        clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        rst;
   logic        start;
   logic [7:0]  a, b;
   logic [15:0] product;
   logic        busy, done;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [15:0] last_prod = '0;

   shift_add_mult dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .busy    (busy),
      .done    (done)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Entered at a negedge with start/a/b already set for acceptance on the next
   // posedge; returns at the negedge of the DONE cycle.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic hold);
      logic [15:0] exp;
      exp = 16'(32'(ia) * 32'(ib));
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("busy_hi", 32'(busy), 32'd1);
         check("done_lo_busy", 32'(done), 32'd0);
         check("prod_hold_busy", 32'(product), 32'(last_prod));
         start = hold | (c == 4) | ($urandom_range(0, 2) == 0);
         a = 8'($urandom);
         b = 8'($urandom);
      end
      @(negedge clk);
      check("done_hi", 32'(done), 32'd1);
      check("busy_lo_done", 32'(busy), 32'd0);
      check("product", 32'(product), 32'(exp));
      last_prod = exp;
      start = hold;
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         check("idle_prod", 32'(product), 32'(last_prod));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      #12;
      check("rst_prod", 32'(product), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b1; a = 8'd13; b = 8'd11;
      run_op(8'd13, 8'd11, 1'b0);
      idle_check(2);

      start = 1'b1; a = 8'hFF; b = 8'hFF;
      run_op(8'hFF, 8'hFF, 1'b0);
      idle_check(1);

      start = 1'b1; a = 8'd3; b = 8'd5;
      run_op(8'd3, 8'd5, 1'b1);
      a = 8'd0; b = 8'd200;
      run_op(8'd0, 8'd200, 1'b1);
      a = 8'd128; b = 8'd2;
      run_op(8'd128, 8'd2, 1'b0);
      idle_check(1);

      for (int i = 0; i < 16; i++) begin
         ra = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : 8'($urandom);
         rb = (i == 2) ? 8'd0 : (i == 1) ? 8'd1 : 8'($urandom);
         start = 1'b1; a = ra; b = rb;
         run_op(ra, rb, 1'b0);
         idle_check($urandom_range(0, 2));
      end

      start = 1'b1; a = 8'd200; b = 8'd100;
      run_op(8'd200, 8'd100, 1'b0);
      @(negedge clk);
      clk_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst_prod", 32'(product), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      #1 rst = 1'b0;
      last_prod = '0;
      clk_en = 1'b1;
      idle_check(1);

      start = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk);
      start = 1'b0;
      for (int c = 1; c <= 4; c++) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_prod", 32'(product), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      rst = 1'b0;
      last_prod = '0;
      start = 1'b1; a = 8'd7; b = 8'd9;
      run_op(8'd7, 8'd9, 1'b0);
      idle_check(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
